fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl_if.sv | 32 +++
 rtl/fifo_read_ctrl.sv | 122 ++++++++++++
 tb/tb_fifo_read_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl_if
// Brief    : Read-side bundle: write pointer in, memory read port, output stream.
// Revision : 1.0
// ============================================================================
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH:0]     wr_ptr;
  logic                    mem_read_en;
  logic [ADDR_WIDTH-1:0]   mem_read_addr;
  logic [DATA_WIDTH-1:0]   mem_read_data;
  logic [ADDR_WIDTH:0]     rd_ptr;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    empty;
  logic [ADDR_WIDTH+1:0]   level;

  modport slave (
    input  wr_ptr, mem_read_data, out_ready,
    output mem_read_en, mem_read_addr, rd_ptr, out_valid, out_data, empty, level
  );

  modport master (
    output wr_ptr, mem_read_data, out_ready,
    input  mem_read_en, mem_read_addr, rd_ptr, out_valid, out_data, empty, level
  );
endinterface
`default_nettype wire

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_ctrl
// Brief    : FIFO read controller with 1-cycle memory latency and 2-entry
//            output skid buffer sustaining one word per cycle.
// Revision : 1.0
// ============================================================================
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  fifo_read_ctrl_if.slave    bus
);
  localparam int c_PTR_W = ADDR_WIDTH + 1;
  localparam int c_LVL_W = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {
    BUF0 = 2'd0,
    BUF1 = 2'd1,
    BUF2 = 2'd2
  } buf_state_t;

  buf_state_t              r_state;
  buf_state_t              w_state_nxt;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic                    r_inflight;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_buf0;
  logic [DATA_WIDTH-1:0]   r_buf1;

  logic [c_PTR_W-1:0]      w_avail;
  logic                    w_avail_nz;
  logic [1:0]              w_cnt;
  logic [1:0]              w_slots;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_rd_en;

  // Modular difference: a full memory (wrap bits differ) yields 2^ADDR_WIDTH, not 0.
  assign w_avail    = bus.wr_ptr - r_rd_ptr;
  assign w_avail_nz = |w_avail;
  assign w_cnt      = r_state;
  assign w_slots    = w_cnt + {1'b0, r_inflight};
  assign w_pop      = r_out_valid && bus.out_ready;
  assign w_push     = r_inflight;
  // A read may target the slot a same-cycle pop is freeing.
  assign w_rd_en    = w_avail_nz && ((w_slots < 2'd2) || ((w_slots == 2'd2) && w_pop));

  assign bus.mem_read_en   = w_rd_en;
  assign bus.mem_read_addr = r_rd_ptr[ADDR_WIDTH-1:0];
  assign bus.rd_ptr        = r_rd_ptr;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_data      = r_buf0;
  assign bus.empty         = !w_avail_nz && (w_slots == 2'd0);
  assign bus.level         = c_LVL_W'(w_avail) + c_LVL_W'(r_inflight) + c_LVL_W'(w_cnt);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= BUF0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != BUF0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUF0: begin
        if (w_push) w_state_nxt = BUF1;
      end
      BUF1: begin
        if (w_push && !w_pop)      w_state_nxt = BUF2;
        else if (!w_push && w_pop) w_state_nxt = BUF0;
      end
      BUF2: begin
        if (w_pop) w_state_nxt = BUF1;
      end
      default: w_state_nxt = BUF0;
    endcase
  end

  // Head lives in r_buf0 so out_data is a plain register and stays put under backpressure.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case (r_state)
        BUF0: begin
          if (w_push) r_buf0 <= bus.mem_read_data;
        end
        BUF1: begin
          if (w_push && w_pop) r_buf0 <= bus.mem_read_data;
          else if (w_push)     r_buf1 <= bus.mem_read_data;
        end
        BUF2: begin
          if (w_pop) r_buf0 <= r_buf1;
        end
        default: begin
          r_buf0 <= r_buf0;
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_ctrl
// Brief    : Directed bench: deep instance for latency/backpressure/reset,
//            shallow instance (ADDR_WIDTH=2) for full-memory and wrap.
// Revision : 1.0
// ============================================================================
module tb_fifo_read_ctrl;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_mis;

  fifo_read_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) if_a ();
  fifo_read_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2))  if_b ();

  fifo_read_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) u_dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if_a.slave)
  );

  fifo_read_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) u_dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if_b.slave)
  );

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: data appears the cycle after the strobe.
  always @(posedge clk) if (if_a.mem_read_en) if_a.mem_read_data <= mem_a[if_a.mem_read_addr];
  always @(posedge clk) if (if_b.mem_read_en) if_b.mem_read_data <= mem_b[if_b.mem_read_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int written;
    int received;
    logic wrapped;
    logic [2:0] prev_rd;

    n_cmp = 0;
    n_mis = 0;
    rstn  = 1'b0;
    if_a.wr_ptr = '0; if_a.out_ready = 1'b0;
    if_b.wr_ptr = '0; if_b.out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem_a[i] = 8'(8'h40 + i);
    for (int i = 0; i < 4; i++)    mem_b[i] = 8'(8'h10 + i);

    // Reset state
    repeat (2) step();
    check("rst_rd_ptr", 32'(if_a.rd_ptr), 32'd0);
    check("rst_out_valid", 32'(if_a.out_valid), 32'd0);
    check("rst_empty", 32'(if_a.empty), 32'd1);
    check("rst_level", 32'(if_a.level), 32'd0);
    check("rst_mem_read_en", 32'(if_a.mem_read_en), 32'd0);
    rstn = 1'b1;
    step();

    // Single word: read in N, out_valid in N+2, empty in N+3
    if_a.out_ready = 1'b1;
    if_a.wr_ptr    = 11'd1;
    #1;
    check("single_rd_en", 32'(if_a.mem_read_en), 32'd1);
    check("single_rd_addr", 32'(if_a.mem_read_addr), 32'd0);
    check("single_empty_n", 32'(if_a.empty), 32'd0);
    check("single_level_n", 32'(if_a.level), 32'd1);
    step();
    check("single_valid_n1", 32'(if_a.out_valid), 32'd0);
    check("single_level_n1", 32'(if_a.level), 32'd1);
    step();
    check("single_valid_n2", 32'(if_a.out_valid), 32'd1);
    check("single_data_n2", 32'(if_a.out_data), 32'h40);
    step();
    check("single_valid_n3", 32'(if_a.out_valid), 32'd0);
    check("single_empty_n3", 32'(if_a.empty), 32'd1);
    check("single_rd_ptr", 32'(if_a.rd_ptr), 32'd1);

    // Backpressure: 8 words, only two reads issue
    if_a.out_ready = 1'b0;
    if_a.wr_ptr    = 11'd9;
    repeat (4) step();
    check("bp_rd_ptr", 32'(if_a.rd_ptr), 32'd3);
    check("bp_level", 32'(if_a.level), 32'd8);
    check("bp_valid", 32'(if_a.out_valid), 32'd1);
    check("bp_data", 32'(if_a.out_data), 32'h41);
    check("bp_rd_en", 32'(if_a.mem_read_en), 32'd0);
    step();
    check("bp_data_stable", 32'(if_a.out_data), 32'h41);
    check("bp_rd_ptr_stable", 32'(if_a.rd_ptr), 32'd3);
    if_a.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_drain_valid", 32'(if_a.out_valid), 32'd1);
      check("bp_drain_data", 32'(if_a.out_data), 32'(8'h41 + k));
      step();
    end
    check("bp_done_valid", 32'(if_a.out_valid), 32'd0);
    check("bp_done_empty", 32'(if_a.empty), 32'd1);
    check("bp_done_level", 32'(if_a.level), 32'd0);
    check("bp_done_rd_ptr", 32'(if_a.rd_ptr), 32'd9);

    // Full memory on the shallow instance
    if_b.wr_ptr = 3'd4;
    #1;
    check("full_empty", 32'(if_b.empty), 32'd0);
    check("full_level", 32'(if_b.level), 32'd4);
    check("full_rd_en", 32'(if_b.mem_read_en), 32'd1);
    check("full_rd_addr", 32'(if_b.mem_read_addr), 32'd0);

    // Stream 10 words through 4 slots, refilling as space frees
    written  = 4;
    received = 0;
    wrapped  = 1'b0;
    prev_rd  = if_b.rd_ptr;
    if_b.out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && received < 10; cyc++) begin
      if (if_b.out_valid) begin
        check("wrap_data", 32'(if_b.out_data), 32'(8'h10 + received));
        received++;
      end
      step();
      if (prev_rd == 3'd3 && if_b.rd_ptr == 3'd4) wrapped = 1'b1;
      prev_rd = if_b.rd_ptr;
      if (written < 10 && 3'(if_b.wr_ptr - if_b.rd_ptr) != 3'd4) begin
        mem_b[if_b.wr_ptr[1:0]] = 8'(8'h10 + written);
        if_b.wr_ptr = if_b.wr_ptr + 3'd1;
        written++;
      end
    end
    check("wrap_count", 32'(received), 32'd10);
    check("wrap_seen_3_to_4", 32'(wrapped), 32'd1);
    check("wrap_final_rd_ptr", 32'(if_b.rd_ptr), 32'd2);
    step();
    check("wrap_final_empty", 32'(if_b.empty), 32'd1);

    // Reset mid-stream with a full buffer and a read in flight
    if_a.out_ready = 1'b0;
    if_a.wr_ptr    = 11'd15;
    repeat (4) step();
    check("mid_pre_valid", 32'(if_a.out_valid), 32'd1);
    if_a.out_ready = 1'b1;
    step();
    if_a.out_ready = 1'b0;
    #3;
    rstn = 1'b0;
    if_a.wr_ptr = '0;
    #1;
    check("mid_rst_valid", 32'(if_a.out_valid), 32'd0);
    check("mid_rst_rd_ptr", 32'(if_a.rd_ptr), 32'd0);
    check("mid_rst_data", 32'(if_a.out_data), 32'd0);
    check("mid_rst_level", 32'(if_a.level), 32'd0);
    check("mid_rst_empty", 32'(if_a.empty), 32'd1);
    step();
    rstn = 1'b1;
    if_a.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mid_post_valid", 32'(if_a.out_valid), 32'd0);
      check("mid_post_level", 32'(if_a.level), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
`default_nettype wire
